wb_stage: RTL and testbench

- Parametrised write-back stage: holds one retiring instruction from MEM/WB and selects its result from the ALU, load-data or private-data source.
- Drives the single register-file write port; supports late load data and two-register (SWAP) write-back over two cycles.
- Sits between the memory stage and the register file, with a ready/stall handshake back to the pipeline.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_data_mux.sv | 23 ++
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source select codes and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PRIV = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE2   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_data_mux.sv
// Result-source mux for write-back; the reserved select code falls back to the ALU result.
module wb_data_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  wb_sel_e           i_sel,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_priv,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_alu;
    case (i_sel)
      WB_MEM:  o_data = i_mem;
      WB_PRIV: o_data = i_priv;
      default: o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry stage register driving the register-file write port,
// with late load data and two-cycle SWAP write-back. WB_FWD_EN adds forwarding outputs.
//
// state    | meaning
// IDLE     | empty, or holding an entry ready to write this cycle
// WAIT_MEM | holding a load entry, waiting for mem_rvalid
// WRITE2   | second (dst2) write of a SWAP entry
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic                  in_swap,
  input  logic [DATA_W-1:0]     in_alu_data,
  input  logic [DATA_W-1:0]     in_priv_data,
  input  logic [REG_ADDR_W-1:0] in_dst_addr,
  input  logic [REG_ADDR_W-1:0] in_dst2_addr,
  input  logic [DATA_W-1:0]     in_data2,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  logic                  r_v;
  logic                  r_reg_write;
  wb_sel_e               r_sel;
  logic                  r_swap;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_priv;
  logic [REG_ADDR_W-1:0] r_dst;
  logic [REG_ADDR_W-1:0] r_dst2;
  logic [DATA_W-1:0]     r_data2;
  wb_state_e             r_state;

  wb_state_e             w_next;
  logic                  w_retire;
  logic [DATA_W-1:0]     w_src;

  wb_data_mux #(.DATA_W(DATA_W)) u_mux (
    .i_sel  (r_sel),
    .i_alu  (r_alu),
    .i_mem  (mem_rdata),
    .i_priv (r_priv),
    .o_data (w_src)
  );

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = r_dst;
    rf_wdata = w_src;
    in_ready = 1'b0;
    case (r_state)
      IDLE, WAIT_MEM: begin
        if (r_state == IDLE && !r_v) begin
          in_ready = 1'b1;
        end else if (r_sel == WB_MEM && !mem_rvalid) begin
          w_next = WAIT_MEM;
        end else begin
          rf_we = r_reg_write;
          if (r_reg_write && r_swap) begin
            w_next = WRITE2;
          end else begin
            in_ready = 1'b1;
            w_retire = 1'b1;
            w_next   = IDLE;
          end
        end
      end
      WRITE2: begin
        rf_we    = 1'b1;
        rf_waddr = r_dst2;
        rf_wdata = r_data2;
        in_ready = 1'b1;
        w_retire = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Flush kills the entry outright, including a pending second SWAP write.
    if (flush) begin
      rf_we    = 1'b0;
      in_ready = 1'b0;
      w_retire = 1'b0;
      w_next   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= 1'b0;
      r_state     <= IDLE;
      r_reg_write <= 1'b0;
      r_sel       <= WB_ALU;
      r_swap      <= 1'b0;
      r_alu       <= '0;
      r_priv      <= '0;
      r_dst       <= '0;
      r_dst2      <= '0;
      r_data2     <= '0;
    end else if (flush) begin
      r_v     <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
      if (in_valid && in_ready) begin
        r_v         <= 1'b1;
        r_reg_write <= in_reg_write;
        r_sel       <= wb_sel_e'(in_wb_sel);
        r_swap      <= in_swap;
        r_alu       <= in_alu_data;
        r_priv      <= in_priv_data;
        r_dst       <= in_dst_addr;
        r_dst2      <= in_dst2_addr;
        r_data2     <= in_data2;
      end else if (w_retire) begin
        r_v <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, back-to-back, load wait, SWAP, flush and reset cases.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic        in_swap;
  logic [15:0] in_alu_data;
  logic [15:0] in_priv_data;
  logic [3:0]  in_dst_addr;
  logic [3:0]  in_dst2_addr;
  logic [15:0] in_data2;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        flush;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_wb_sel    (in_wb_sel),
    .in_swap      (in_swap),
    .in_alu_data  (in_alu_data),
    .in_priv_data (in_priv_data),
    .in_dst_addr  (in_dst_addr),
    .in_dst2_addr (in_dst2_addr),
    .in_data2     (in_data2),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] sel, input logic sw,
                       input logic [15:0] alu, input logic [15:0] priv,
                       input logic [3:0] dst, input logic [3:0] dst2, input logic [15:0] d2);
    in_valid     = 1'b1;
    in_reg_write = rw;
    in_wb_sel    = sel;
    in_swap      = sw;
    in_alu_data  = alu;
    in_priv_data = priv;
    in_dst_addr  = dst;
    in_dst2_addr = dst2;
    in_data2     = d2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] a,
                        input logic [15:0] d, input logic rdy);
    check({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      check({tag, "_addr"}, {28'd0, rf_waddr}, {28'd0, a});
      check({tag, "_data"}, {16'd0, rf_wdata}, {16'd0, d});
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, {31'd0, rdy});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_wb_sel = 2'd0; in_swap = 1'b0;
    in_alu_data = '0; in_priv_data = '0; in_dst_addr = '0; in_dst2_addr = '0; in_data2 = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_addr", {28'd0, rf_waddr}, 32'd0);
    check("rst_data", {16'd0, rf_wdata}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);

    // single ALU op
    drive(1, 2'd0, 0, 16'h1234, 16'h0, 4'h3, 4'h0, 16'h0);
    step(); in_valid = 1'b0; settle();
    chk_wr("alu", 1, 4'h3, 16'h1234, 1);
    step(); chk_wr("alu_idle", 0, 4'h0, 16'h0, 1);

    // back-to-back ALU ops
    drive(1, 2'd0, 0, 16'h0011, 16'h0, 4'h1, 4'h0, 16'h0);
    step(); drive(1, 2'd0, 0, 16'h0022, 16'h0, 4'h2, 4'h0, 16'h0); settle();
    chk_wr("b2b1", 1, 4'h1, 16'h0011, 1);
    step(); drive(1, 2'd0, 0, 16'h0033, 16'h0, 4'h3, 4'h0, 16'h0); settle();
    chk_wr("b2b2", 1, 4'h2, 16'h0022, 1);
    step(); in_valid = 1'b0; settle();
    chk_wr("b2b3", 1, 4'h3, 16'h0033, 1);
    step(); chk_wr("b2b_end", 0, 4'h0, 16'h0, 1);

    // load with rvalid three cycles after capture
    drive(1, 2'd1, 0, 16'h0, 16'h0, 4'h5, 4'h0, 16'h0);
    step(); in_valid = 1'b0; settle();
    chk_wr("ld_w1", 0, 4'h0, 16'h0, 0);
    step(); chk_wr("ld_w2", 0, 4'h0, 16'h0, 0);
    step(); chk_wr("ld_w3", 0, 4'h0, 16'h0, 0);
    step(); mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; settle();
    chk_wr("ld_wr", 1, 4'h5, 16'hBEEF, 1);
    step(); mem_rvalid = 1'b0; settle();
    chk_wr("ld_done", 0, 4'h0, 16'h0, 1);

    // SWAP
    drive(1, 2'd0, 1, 16'h00AA, 16'h0, 4'h2, 4'h7, 16'h0055);
    step(); in_valid = 1'b0; settle();
    chk_wr("sw_c1", 1, 4'h2, 16'h00AA, 0);
    step(); chk_wr("sw_c2", 1, 4'h7, 16'h0055, 1);
    step(); chk_wr("sw_end", 0, 4'h0, 16'h0, 1);

    // SWAP to the same register: two ordered writes
    drive(1, 2'd0, 1, 16'h0101, 16'h0, 4'h6, 4'h6, 16'h0202);
    step(); in_valid = 1'b0; settle();
    chk_wr("swsame1", 1, 4'h6, 16'h0101, 0);
    step(); chk_wr("swsame2", 1, 4'h6, 16'h0202, 1);
    step();

    // flush during WRITE2
    drive(1, 2'd0, 1, 16'h00AA, 16'h0, 4'h2, 4'h7, 16'h0055);
    step(); in_valid = 1'b0; settle();
    chk_wr("fl2_c1", 1, 4'h2, 16'h00AA, 0);
    step(); flush = 1'b1; settle();
    chk_wr("fl2_fl", 0, 4'h0, 16'h0, 0);
    step(); flush = 1'b0; settle();
    chk_wr("fl2_after", 0, 4'h0, 16'h0, 1);

    // flush during WAIT_MEM, then a stray rvalid is ignored
    drive(1, 2'd1, 0, 16'h0, 16'h0, 4'h5, 4'h0, 16'h0);
    step(); in_valid = 1'b0; step(); flush = 1'b1; settle();
    chk_wr("flm_fl", 0, 4'h0, 16'h0, 0);
    step(); flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111; settle();
    chk_wr("flm_after", 0, 4'h0, 16'h0, 1);
    step(); mem_rvalid = 1'b0;

    // reset during WAIT_MEM
    drive(1, 2'd1, 0, 16'h7777, 16'h8888, 4'h9, 4'hA, 16'h9999);
    step(); in_valid = 1'b0; step(); rst = 1'b1;
    step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h2222; settle();
    check("rstm_we", {31'd0, rf_we}, 32'd0);
    check("rstm_addr", {28'd0, rf_waddr}, 32'd0);
    check("rstm_data", {16'd0, rf_wdata}, 32'd0);
    check("rstm_rdy", {31'd0, in_ready}, 32'd1);
    step(); mem_rvalid = 1'b0;

    // PRIV select and reserved select
    drive(1, 2'd2, 0, 16'h1111, 16'hCAFE, 4'h4, 4'h0, 16'h0);
    step(); drive(1, 2'd3, 0, 16'h4321, 16'hDEAD, 4'h8, 4'h0, 16'h0); settle();
    chk_wr("priv", 1, 4'h4, 16'hCAFE, 1);
    step(); in_valid = 1'b0; settle();
    chk_wr("rsvd", 1, 4'h8, 16'h4321, 1);
    step();

    // reg_write=0 with swap set: retires in one cycle, no write
    drive(0, 2'd0, 1, 16'h5555, 16'h0, 4'hB, 4'hC, 16'h6666);
    step(); in_valid = 1'b0; settle();
    chk_wr("nowr", 0, 4'h0, 16'h0, 1);
    step(); chk_wr("nowr_next", 0, 4'h0, 16'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
